// File: rtl/cmi_serial_rx.sv
// cmi_serial_rx: serial CMI receiver; recovers pair alignment by bit-slipping, tracks lock, decodes data.
// Optional build macro CMI_ALT_CHECK_EN adds the 1-pair polarity alternation check.
module cmi_serial_rx #(
    parameter int WINDOW        = 16,
    parameter int LOCK_WINDOWS  = 2,
    parameter int UNLOCK_THRESH = 4
) (
    input  logic clk_sig,
    input  logic reset_sig,
    input  logic serial_sig,
    output logic decode_sig,
    output logic decode_valid_sig,
    output logic locked_sig,
    output logic violation_sig,
    output logic slip_sig,
    output logic state_dbg
);

    localparam int WIN_W = $clog2(WINDOW) + 1;
    localparam int VIO_W = $clog2(UNLOCK_THRESH) + 1;
    localparam int CLN_W = $clog2(LOCK_WINDOWS) + 1;

    // Terminal values: the pair being evaluated is the last one of its window / count.
    localparam logic [WIN_W-1:0] WIN_END = WIN_W'(WINDOW - 1);
    localparam logic [VIO_W-1:0] VIO_END = VIO_W'(UNLOCK_THRESH - 1);
    localparam logic [CLN_W-1:0] CLN_END = CLN_W'(LOCK_WINDOWS - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic             half_q, half_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [VIO_W-1:0] vio_q, vio_d;
    logic [CLN_W-1:0] cln_q, cln_d;
    logic             decode_q, decode_d;
    logic             valid_q, valid_d;
    logic             viol_q, viol_d;
    logic             slip_q, slip_d;
    logic [1:0]       pair;
    logic             bad;
    logic             do_slip;
`ifdef CMI_ALT_CHECK_EN
    logic             alt_valid_q, alt_valid_d;
    logic             alt_pol_q, alt_pol_d;
    logic             is_one;
`endif

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q     <= HUNT;
            phase_q     <= 1'b0;
            half_q      <= 1'b0;
            win_q       <= '0;
            vio_q       <= '0;
            cln_q       <= '0;
            decode_q    <= 1'b0;
            valid_q     <= 1'b0;
            viol_q      <= 1'b0;
            slip_q      <= 1'b0;
`ifdef CMI_ALT_CHECK_EN
            alt_valid_q <= 1'b0;
            alt_pol_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            win_q       <= win_d;
            vio_q       <= vio_d;
            cln_q       <= cln_d;
            decode_q    <= decode_d;
            valid_q     <= valid_d;
            viol_q      <= viol_d;
            slip_q      <= slip_d;
`ifdef CMI_ALT_CHECK_EN
            alt_valid_q <= alt_valid_d;
            alt_pol_q   <= alt_pol_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        half_d   = half_q;
        win_d    = win_q;
        vio_d    = vio_q;
        cln_d    = cln_q;
        decode_d = decode_q;
        valid_d  = 1'b0;
        viol_d   = 1'b0;
        slip_d   = 1'b0;
        do_slip  = 1'b0;
        pair     = {half_q, serial_sig};
        bad      = (pair == 2'b10);
`ifdef CMI_ALT_CHECK_EN
        alt_valid_d = alt_valid_q;
        alt_pol_d   = alt_pol_q;
        is_one      = (pair[1] == pair[0]);
        if (is_one && alt_valid_q && (pair[0] == alt_pol_q)) begin
            bad = 1'b1;
        end
`endif

        if (!phase_q) begin
            half_d  = serial_sig;
            phase_d = 1'b1;
        end else begin
            phase_d = 1'b0;
`ifdef CMI_ALT_CHECK_EN
            if (is_one && !bad) begin
                alt_valid_d = 1'b1;
                alt_pol_d   = pair[0];
            end
`endif
            if (state_q == HUNT) begin
                if (bad) begin
                    viol_d  = 1'b1;
                    do_slip = 1'b1;
                    cln_d   = '0;
                end else if (win_q == WIN_END) begin
                    win_d = '0;
                    if (cln_q == CLN_END) begin
                        state_d = LOCK;
                        cln_d   = '0;
                    end else begin
                        cln_d = cln_q + 1'b1;
                    end
                end else begin
                    win_d = win_q + 1'b1;
                end
            end else begin
                if (bad) begin
                    viol_d = 1'b1;
                    // Threshold takes priority over a coincident window end.
                    if (vio_q == VIO_END) begin
                        state_d = HUNT;
                        do_slip = 1'b1;
                        cln_d   = '0;
                    end else if (win_q == WIN_END) begin
                        win_d = '0;
                        vio_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                        vio_d = vio_q + 1'b1;
                    end
                end else begin
                    decode_d = (pair != 2'b01);
                    valid_d  = 1'b1;
                    if (win_q == WIN_END) begin
                        win_d = '0;
                        vio_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end

            // Slip: the current bit becomes the first half of the next pair.
            if (do_slip) begin
                half_d  = serial_sig;
                phase_d = 1'b1;
                slip_d  = 1'b1;
                win_d   = '0;
                vio_d   = '0;
`ifdef CMI_ALT_CHECK_EN
                alt_valid_d = 1'b0;
`endif
            end
        end
    end

    assign decode_sig       = decode_q;
    assign decode_valid_sig = valid_q;
    assign locked_sig       = (state_q == LOCK);
    assign violation_sig    = viol_q;
    assign slip_sig         = slip_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_cmi_serial_rx.sv
// tb_cmi_serial_rx: directed bench for cmi_serial_rx (alignment, lock, unlock, reset, alternation, noise).
// Inputs change on the falling edge; outputs are sampled on the falling edge after each evaluation.
module tb_cmi_serial_rx;

    logic clk_sig = 1'b0;
    logic reset_sig = 1'b0;
    logic serial_sig = 1'b0;
    logic decode_sig, decode_valid_sig, locked_sig, violation_sig, slip_sig, state_dbg;

    int   n_vec = 0;
    int   n_err = 0;
    logic pol;
    int   src_idx;
    logic [0:0] exp_q[$];

    cmi_serial_rx dut (
        .clk_sig          (clk_sig),
        .reset_sig        (reset_sig),
        .serial_sig       (serial_sig),
        .decode_sig       (decode_sig),
        .decode_valid_sig (decode_valid_sig),
        .locked_sig       (locked_sig),
        .violation_sig    (violation_sig),
        .slip_sig         (slip_sig),
        .state_dbg        (state_dbg)
    );

    always #5 clk_sig = ~clk_sig;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_sig = b;
        @(posedge clk_sig);
        @(negedge clk_sig);
    endtask

    function automatic logic src_bit(input int i);
        case (i % 5)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Encoder: data 0 -> 01, data 1 -> 00/11 alternating polarity.
    task automatic next_data_pair(output logic [1:0] p, output logic d);
        d = src_bit(src_idx);
        src_idx++;
        if (d) begin
            p   = pol ? 2'b11 : 2'b00;
            pol = ~pol;
        end else begin
            p = 2'b01;
        end
    endtask

    task automatic do_reset();
        reset_sig = 1'b1;
        serial_sig = 1'b0;
        @(negedge clk_sig);
        @(negedge clk_sig);
        reset_sig = 1'b0;
        pol = 1'b0;
        src_idx = 0;
        exp_q.delete();
    endtask

    task automatic send_data(input logic was_locked, input logic lock_after, input string tag);
        logic [1:0] p;
        logic d;
        logic [0:0] e;
        next_data_pair(p, d);
        exp_q.push_back(d);
        send_bit(p[1]);
        if (was_locked) check({tag, "_valid_ph0"}, decode_valid_sig, 1'b0);
        send_bit(p[0]);
        e = exp_q.pop_front();
        check({tag, "_viol"}, violation_sig, 1'b0);
        check({tag, "_slip"}, slip_sig, 1'b0);
        check({tag, "_valid"}, decode_valid_sig, was_locked);
        if (was_locked) check({tag, "_data"}, decode_sig, e);
        check({tag, "_locked"}, locked_sig, lock_after);
        check({tag, "_state"}, state_dbg, lock_after);
    endtask

    task automatic send_viol(input logic lock_after, input logic slip_exp, input string tag);
        send_bit(1'b1);
        send_bit(1'b0);
        check({tag, "_viol"}, violation_sig, 1'b1);
        check({tag, "_valid"}, decode_valid_sig, 1'b0);
        check({tag, "_slip"}, slip_sig, slip_exp);
        check({tag, "_locked"}, locked_sig, lock_after);
    endtask

    task automatic lock_up(input string tag);
        for (int k = 1; k <= 32; k++) send_data(1'b0, k == 32, tag);
    endtask

    initial begin
        logic [1:0] p;
        logic d;

        // Reset state
        #1 reset_sig = 1'b1;
        @(negedge clk_sig);
        check("rst_decode", decode_sig, 1'b0);
        check("rst_valid", decode_valid_sig, 1'b0);
        check("rst_locked", locked_sig, 1'b0);
        check("rst_viol", violation_sig, 1'b0);
        check("rst_slip", slip_sig, 1'b0);
        check("rst_state", state_dbg, 1'b0);
        do_reset();

        // Aligned stream: lock exactly on pair 32, then decode with 1 clk latency
        lock_up("align_lock");
        for (int k = 0; k < 20; k++) send_data(1'b1, 1'b1, "align_dec");

        // Polarity repeat in LOCK: proper 1, a 0, then a 1-pair repeating the last polarity
        p = pol ? 2'b11 : 2'b00;
        pol = ~pol;
        send_pair_checks(p, 1'b1, "alt_first");
        send_pair_checks(2'b01, 1'b0, "alt_zero");
        p = pol ? 2'b00 : 2'b11;
        send_bit(p[1]);
        send_bit(p[0]);
`ifdef CMI_ALT_CHECK_EN
        check("alt_repeat_viol", violation_sig, 1'b1);
        check("alt_repeat_valid", decode_valid_sig, 1'b0);
`else
        check("alt_repeat_viol", violation_sig, 1'b0);
        check("alt_repeat_valid", decode_valid_sig, 1'b1);
        check("alt_repeat_data", decode_sig, 1'b1);
`endif
        check("alt_repeat_locked", locked_sig, 1'b1);

        // Asynchronous reset mid-cycle drops a pending valid pulse
        send_data(1'b1, 1'b1, "pre_rst");
        #2 reset_sig = 1'b1;
        #1;
        check("arst_valid", decode_valid_sig, 1'b0);
        check("arst_locked", locked_sig, 1'b0);
        check("arst_decode", decode_sig, 1'b0);
        check("arst_viol", violation_sig, 1'b0);
        check("arst_slip", slip_sig, 1'b0);
        check("arst_state", state_dbg, 1'b0);
        @(negedge clk_sig);
        reset_sig = 1'b0;
        pol = 1'b0;
        src_idx = 0;
        exp_q.delete();
        lock_up("relock");

        // Window A: 3 violations (last one on the window's final pair) keep lock
        for (int pos = 0; pos < 16; pos++) begin
            if (pos == 2 || pos == 5 || pos == 15) send_viol(1'b1, 1'b0, "winA_bad");
            else send_data(1'b1, 1'b1, "winA_ok");
        end
        // Window B: 4th violation coincides with window end; unlock and slip win
        for (int pos = 0; pos < 16; pos++) begin
            if (pos == 0 || pos == 3 || pos == 6) send_viol(1'b1, 1'b0, "winB_bad");
            else if (pos == 15) send_viol(1'b0, 1'b1, "winB_unlock");
            else send_data(1'b1, 1'b1, "winB_ok");
        end
        check("winB_state", state_dbg, 1'b0);

        // One-bit delayed stream: leading 1 forms a 10 pair, single slip realigns
        do_reset();
        next_data_pair(p, d);
        send_bit(1'b1);
        send_bit(p[1]);
        check("dly_slip", slip_sig, 1'b1);
        check("dly_viol", violation_sig, 1'b1);
        check("dly_locked", locked_sig, 1'b0);
        send_bit(p[0]);
        check("dly_first_viol", violation_sig, 1'b0);
        check("dly_first_slip", slip_sig, 1'b0);
        for (int k = 2; k <= 32; k++) send_data(1'b0, k == 32, "dly_lock");
        for (int k = 0; k < 10; k++) send_data(1'b1, 1'b1, "dly_dec");

        // Noise with an injected 1,0,1,1,0 burst every 16 bits: violations in either alignment
        do_reset();
        for (int r = 0; r < 95; r++) begin
            for (int b = 0; b < 21; b++) begin
                logic bit_v;
                logic [4:0] burst;
                burst = 5'b10110;
                bit_v = (b < 16) ? 1'($urandom_range(1, 0)) : burst[20 - b];
                send_bit(bit_v);
                check("noise_locked", locked_sig, 1'b0);
                check("noise_no_x",
                      32'($isunknown({decode_sig, decode_valid_sig, locked_sig,
                                      violation_sig, slip_sig, state_dbg})), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hand-built pair in LOCK that must decode cleanly to exp_d.
    task automatic send_pair_checks(input logic [1:0] p, input logic exp_d, input string tag);
        send_bit(p[1]);
        send_bit(p[0]);
        check({tag, "_viol"}, violation_sig, 1'b0);
        check({tag, "_valid"}, decode_valid_sig, 1'b1);
        check({tag, "_data"}, decode_sig, exp_d);
    endtask

endmodule
